clause_scan: RTL and testbench

Sits between the BCP decision/implication source and clause_db.
- Accepts one assigned variable index.
- Reads that variable's clause-occurrence mask from clause_db.
- Emits the indices of all set bits, one per handshake, in ascending order, to the clause evaluator.
- Drives clause_db read port directly and consumes clause_db_out.

---
 rtl/bcp_pkg.sv | 13 +
 rtl/clause_scan_if.sv | 23 ++
 rtl/lsb_index_enc.sv | 20 ++
 rtl/clause_scan.sv | 104 ++++++++++
 tb/tb_clause_scan.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/bcp_pkg.sv
// Shared widths, index typedefs and the scan state encoding for the BCP clause scanner.
package bcp_pkg;
  localparam int CLAUSE_NUM     = 7;
  localparam int CLAUSE_NUM_LOG = 3;
  localparam int VAR_NUM        = 7;
  localparam int VAR_NUM_LOG    = 3;

  typedef logic [CLAUSE_NUM_LOG-1:0] clause_idx_t;
  typedef logic [VAR_NUM_LOG-1:0]    var_idx_t;
  typedef logic [CLAUSE_NUM-1:0]     clause_mask_t;

  typedef enum logic [2:0] {IDLE, READ, LOAD, EMIT, DONE} scan_state_t;
endpackage

// File: rtl/clause_scan_if.sv
// Request (var_*) and clause-index (cl_*) handshakes of the clause scanner.
// Both follow valid/ready: a transfer happens on a clock edge where valid and ready are both high;
// the producer keeps valid and its payload stable until that edge.
interface clause_scan_if;
  logic                   var_valid;
  logic                   var_ready;
  bcp_pkg::var_idx_t      var_id;
  logic                   cl_valid;
  logic                   cl_ready;
  bcp_pkg::clause_idx_t   cl_idx;
  bcp_pkg::var_idx_t      cl_var;
  logic                   cl_last;

  modport master (
    output var_valid, var_id, cl_ready,
    input  var_ready, cl_valid, cl_idx, cl_var, cl_last
  );

  modport slave (
    input  var_valid, var_id, cl_ready,
    output var_ready, cl_valid, cl_idx, cl_var, cl_last
  );
endinterface

// File: rtl/lsb_index_enc.sv
// Combinational lowest-set-bit encoder with an exactly-one-bit-set flag.
module lsb_index_enc
  import bcp_pkg::*;
(
  input  clause_mask_t mask,
  output clause_idx_t  index,
  output logic         onehot_flag
);

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    index = '0;
    for (int i = CLAUSE_NUM - 1; i >= 0; i--) begin
      if (mask[i]) index = clause_idx_t'(i);
    end
  end

  assign onehot_flag = (mask != '0) && ((mask & (mask - clause_mask_t'(1))) == '0);

endmodule

// File: rtl/clause_scan.sv
// Reads a variable's clause-occurrence row from clause_db and streams its set-bit indices in
// ascending order. Optional SCAN_SAT_FILTER_EN masks out already-satisfied clauses at load time.
module clause_scan
  import bcp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  clause_scan_if.slave  bus,
`ifdef SCAN_SAT_FILTER_EN
  input  clause_mask_t  clause_sat_mask,
`endif
  output logic          clause_db_en,
  output logic          clause_db_write,
  output var_idx_t      clause_db_address,
  input  clause_mask_t  clause_db_out,
  output logic          scan_done,
  output logic          busy,
  output scan_state_t   dbg_state
);

  scan_state_t  state;
  var_idx_t     var_q;
  clause_mask_t mask_q;
  clause_mask_t loaded;
  clause_idx_t  low_idx;
  logic         low_onehot;
  logic         cl_valid_q;

  lsb_index_enc u_enc (
    .mask        (mask_q),
    .index       (low_idx),
    .onehot_flag (low_onehot)
  );

`ifdef SCAN_SAT_FILTER_EN
  assign loaded = clause_db_out & ~clause_sat_mask;
`else
  assign loaded = clause_db_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      var_q        <= '0;
      mask_q       <= '0;
      clause_db_en <= 1'b0;
      cl_valid_q   <= 1'b0;
      scan_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.var_valid) begin
            var_q        <= bus.var_id;
            state        <= READ;
            clause_db_en <= 1'b1;
            busy         <= 1'b1;
          end
        end
        READ: begin
          state        <= LOAD;
          clause_db_en <= 1'b0;
        end
        // clause_db_out is only valid in this cycle; it clears once en has dropped.
        LOAD: begin
          mask_q <= loaded;
          if (loaded == '0) begin
            state     <= DONE;
            scan_done <= 1'b1;
          end else begin
            state      <= EMIT;
            cl_valid_q <= 1'b1;
          end
        end
        EMIT: begin
          if (bus.cl_ready) begin
            mask_q <= mask_q & (mask_q - clause_mask_t'(1));
            if (low_onehot) begin
              state      <= DONE;
              cl_valid_q <= 1'b0;
              scan_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          scan_done <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.var_ready     = (state == IDLE);
  assign bus.cl_valid      = cl_valid_q;
  assign bus.cl_idx        = low_idx;
  assign bus.cl_var        = var_q;
  assign bus.cl_last       = low_onehot && (state == EMIT);
  assign clause_db_write   = 1'b0;
  assign clause_db_address = var_q;
  assign dbg_state         = state;

endmodule

// File: tb/tb_clause_scan.sv
// Bench for clause_scan: clause_db row model, directed scans from the test plan, then random scans
// checked against a list-of-set-bits reference.
module tb_clause_scan;
  import bcp_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         clause_db_en, clause_db_write;
  var_idx_t     clause_db_address;
  clause_mask_t clause_db_out;
  clause_mask_t sat_mask;
  logic         scan_done, busy;
  scan_state_t  dbg_state;

  clause_mask_t mem [0:7];
  logic [6:0]   exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  clause_scan_if bus();

  clause_scan dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
`ifdef SCAN_SAT_FILTER_EN
    .clause_sat_mask   (sat_mask),
`endif
    .clause_db_en      (clause_db_en),
    .clause_db_write   (clause_db_write),
    .clause_db_address (clause_db_address),
    .clause_db_out     (clause_db_out),
    .scan_done         (scan_done),
    .busy              (busy),
    .dbg_state         (dbg_state)
  );

  always #5 clk = ~clk;

  // clause_db: registered read, output cleared whenever en is low.
  always @(posedge clk) begin
    if (rst)               clause_db_out <= '0;
    else if (clause_db_en) clause_db_out <= mem[clause_db_address];
    else                   clause_db_out <= '0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic clause_mask_t effective_row(input int v);
    clause_mask_t r;
    r = mem[v];
`ifdef SCAN_SAT_FILTER_EN
    r = r & ~sat_mask;
`endif
    return r;
  endfunction

  // Entered and left at posedge+1. mode: 0 ready always, 1 toggle 1-0-1-0, 2 random.
  task automatic do_scan(input int v, input int mode, input bit hold);
    clause_mask_t row;
    int           hi, first, k;
    bit           done, held_pend;
    logic [6:0]   cur, held;
    row = effective_row(v);
    hi = -1;
    for (int b = 0; b < CLAUSE_NUM; b++) if (row[b]) hi = b;
    for (int b = 0; b < CLAUSE_NUM; b++)
      if (row[b]) exp_q.push_back({(b == hi) ? 1'b1 : 1'b0, 3'(v), 3'(b)});

    for (int w = 0; w < 50 && !bus.var_ready; w++) begin @(posedge clk); #1; end
    check("idle_wait", 32'(bus.var_ready), 1);
    bus.var_valid = 1'b1;
    bus.var_id    = var_idx_t'(v);
    @(posedge clk); #1;
    if (!hold) bus.var_valid = 1'b0;

    first = -1; done = 0; held_pend = 0; held = '0;
    for (k = 0; k < 100 && !done; k++) begin
      case (mode)
        0:       bus.cl_ready = 1'b1;
        1:       bus.cl_ready = (k % 2 == 0);
        default: bus.cl_ready = 1'($urandom_range(0, 1));
      endcase
      if (hold) bus.var_id = var_idx_t'($urandom_range(0, VAR_NUM - 1));
      @(negedge clk);
      cur = {bus.cl_last, bus.cl_var, bus.cl_idx};
      check("busy_in_scan", 32'(busy), 1);
      check("ready_low_in_scan", 32'(bus.var_ready), 0);
      if (k == 0) begin
        check("db_en_read", 32'(clause_db_en), 1);
        check("db_addr", 32'(clause_db_address), 32'(v));
      end
      if (bus.cl_valid && first < 0) begin
        first = k;
        check("first_latency", 32'(k), 2);
      end
      if (held_pend && bus.cl_valid) check("held_stable", 32'(cur), 32'(held));
      held_pend = 0;
      if (bus.cl_valid && bus.cl_ready) begin
        if (exp_q.size() == 0) check("extra_index", 32'(cur), 0);
        else                   check("emit", 32'(cur), 32'(exp_q.pop_front()));
      end else if (bus.cl_valid) begin
        held = cur; held_pend = 1;
      end
      if (scan_done) begin
        done = 1;
        if (row == '0) check("zero_done_latency", 32'(k), 2);
      end
      @(posedge clk); #1;
    end
    if (!done) check("done_timeout", 0, 1);
    check("valid_seen", 32'(first >= 0), 32'(row != '0));
    check("exp_drained", 32'(exp_q.size()), 0);
    exp_q.delete();
    @(negedge clk);
    check("done_pulse", 32'(scan_done), 0);
    check("ready_back", 32'(bus.var_ready), 1);
    check("busy_clear", 32'(busy), 0);
    if (hold) bus.var_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.var_valid = 1'b0; bus.var_id = '0; bus.cl_ready = 1'b0;
    sat_mask = '0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem[0] = 7'b0010001;
    mem[1] = 7'b0000011;
    mem[5] = 7'b1111000;
    mem[6] = 7'b1111000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_var_ready", 32'(bus.var_ready), 1);
    check("rst_cl_valid", 32'(bus.cl_valid), 0);
    check("rst_outputs", 32'({scan_done, busy, clause_db_en, clause_db_write, bus.cl_last}), 0);
    check("rst_idx_var_addr", 32'({bus.cl_idx, bus.cl_var, clause_db_address}), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    do_scan(0, 0, 0);
    do_scan(5, 1, 0);
    mem[2] = 7'b0000000;
    do_scan(2, 0, 0);
    do_scan(5, 0, 1);

    // Reset while emitting: index 3 taken, then rst lands with 4 pending.
    bus.cl_ready = 1'b1;
    bus.var_valid = 1'b1; bus.var_id = 3'd5;
    @(posedge clk); #1;
    bus.var_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("pre_rst_idx", 32'({bus.cl_valid, bus.cl_idx}), 32'({1'b1, 3'd3}));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_outputs", 32'({bus.cl_valid, busy, scan_done}), 0);
    check("abort_ready", 32'(bus.var_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(scan_done), 0);
    end
    @(posedge clk); #1;
    do_scan(1, 0, 0);

`ifdef SCAN_SAT_FILTER_EN
    sat_mask = 7'b0101000;
    do_scan(6, 0, 0);
    sat_mask = 7'b1111000;
    do_scan(6, 0, 0);
    sat_mask = '0;
`endif

    for (int it = 0; it < 25; it++) begin
      int v;
      v = $urandom_range(0, VAR_NUM - 1);
      mem[v] = clause_mask_t'($urandom_range(0, 127));
`ifdef SCAN_SAT_FILTER_EN
      sat_mask = clause_mask_t'($urandom_range(0, 127));
`endif
      do_scan(v, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
